// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner: synchronise, debounce and resolve one pad's up/down buttons; free-running timing_tick.
// Define LAST_PRESS_PRIORITY_EN to let the most recently pressed button win when both are held.
module pad_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int TICK_DIV = 325000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic up_out,
   output logic down_out,
   output logic timing_tick
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [1:0] IDLE = 2'd0, PRESS_WAIT = 2'd1, PRESSED = 2'd2, RELEASE_WAIT = 2'd3;
   // Per-button vectors: bit 0 is up, bit 1 is down.
   logic [1:0] s1_q, s2_q, deb_q, deb_d;
   logic [1:0][1:0] st_q, st_d;
   logic [1:0][CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic up_d, down_d, tick_d;
   always_comb begin
      deb_d = deb_q;
      st_d = st_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         case (st_q[i])
            IDLE: if (s2_q[i]) begin st_d[i] = PRESS_WAIT; cnt_d[i] = '0; end
            PRESS_WAIT:
               if (!s2_q[i]) st_d[i] = IDLE;
               else if (cnt_q[i] == CNT_MAX) begin st_d[i] = PRESSED; deb_d[i] = 1'b1; end
               else cnt_d[i] = cnt_q[i] + CW'(1);
            PRESSED: if (!s2_q[i]) begin st_d[i] = RELEASE_WAIT; cnt_d[i] = '0; end
            default:
               if (s2_q[i]) st_d[i] = PRESSED;
               else if (cnt_q[i] == CNT_MAX) begin st_d[i] = IDLE; deb_d[i] = 1'b0; end
               else cnt_d[i] = cnt_q[i] + CW'(1);
         endcase
      end
      tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + TW'(1);
      tick_d = tick_cnt_d == TICK_MAX;
   end
`ifdef LAST_PRESS_PRIORITY_EN
   // last: 0 = up rose most recently, 1 = down; tie marks a simultaneous rise.
   logic last_q, last_d, tie_q, tie_d;
   logic [1:0] rise;
   always_comb begin
      rise = deb_d & ~deb_q;
      last_d = (rise == 2'b01) ? 1'b0 : (rise == 2'b10) ? 1'b1 : last_q;
      tie_d = (rise == 2'b11) ? 1'b1 : (|rise) ? 1'b0 : tie_q;
      up_d = deb_q[0] & (~deb_q[1] | (~last_q & ~tie_q));
      down_d = deb_q[1] & (~deb_q[0] | (last_q & ~tie_q));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b0;
         tie_q <= 1'b0;
      end else begin
         last_q <= last_d;
         tie_q <= tie_d;
      end
   end
`else
   always_comb begin
      up_d = deb_q[0] & ~deb_q[1];
      down_d = deb_q[1] & ~deb_q[0];
   end
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         deb_q <= '0;
         st_q <= {IDLE, IDLE};
         cnt_q <= '0;
         tick_cnt_q <= '0;
         up_out <= 1'b0;
         down_out <= 1'b0;
         timing_tick <= 1'b0;
      end else begin
         s1_q <= {btn_down_raw, btn_up_raw};
         s2_q <= s1_q;
         deb_q <= deb_d;
         st_q <= st_d;
         cnt_q <= cnt_d;
         tick_cnt_q <= tick_cnt_d;
         up_out <= up_d;
         down_out <= down_d;
         timing_tick <= tick_d;
      end
   end
endmodule
